// File: rtl/tbus_dcache_pkg.sv
// Shared types and helpers for the tbus L1 data cache.
// No logic, no latency, no flow control.
// Operation codes mirror `TBUS_READ / `TBUS_WRITE from defines.sv.
package tbus_dcache_pkg;

    localparam logic [1:0] TBUS_READ  = 2'b00;
    localparam logic [1:0] TBUS_WRITE = 2'b01;

    // One latched tbus request; held for the whole operation.
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] wmask;
        logic [1:0]  op;
    } req_t;

    // 64-bit word address: byte offset bits dropped.
    function automatic logic [63:0] word_addr(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped cache; one combinational read port.
// Latency: read is combinational, writes land at the next clock edge.
// Backpressure: none; the controller owns all sequencing.
// Ports: i_idx selects the set for read and write; i_rd_beat / i_wr_beat select the
//        word; i_we writes one word; i_tag_we stores i_tag and sets the line valid.
module dcache_array #(
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned TAG_W      = 53
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [$clog2(SETS)-1:0]       i_idx,
    input  logic [$clog2(LINE_BEATS)-1:0] i_rd_beat,
    output logic [63:0]                   o_rd_data,
    output logic                          o_valid,
    output logic [TAG_W-1:0]              o_tag,
    input  logic                          i_we,
    input  logic [$clog2(LINE_BEATS)-1:0] i_wr_beat,
    input  logic [63:0]                   i_wr_data,
    input  logic                          i_tag_we,
    input  logic [TAG_W-1:0]              i_tag
);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned BEAT_W = $clog2(LINE_BEATS);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [63:0]      r_data [SETS*LINE_BEATS];

    // Only the valid bits are reset: that alone invalidates every line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_tag_we) r_tag[i_idx] <= i_tag;
        if (i_we)     r_data[{i_idx, i_wr_beat}] <= i_wr_data;
    end

    logic [IDX_W+BEAT_W-1:0] w_rd_sel;
    assign w_rd_sel  = {i_idx, i_rd_beat};
    assign o_rd_data = r_data[w_rd_sel];
    assign o_valid   = r_valid[i_idx];
    assign o_tag     = r_tag[i_idx];

endmodule

// File: rtl/defines.sv
// tbus operation-type encodings shared with the LSU side of the trinity bus.
// Pure macro file: no logic, no latency, no flow control.
// Guarded so it can be pulled into several compilation units.
`ifndef TBUS_DEFINES_SV
`define TBUS_DEFINES_SV
`define TBUS_OPTYPE_RANGE 1:0
`define TBUS_READ         2'b00
`define TBUS_WRITE        2'b01
`endif

// File: rtl/tbus_dcache.sv
// Direct-mapped write-through no-write-allocate L1 D$: tbus slave, burst memory master.
// Latency: read hit done 2 cycles after accept; misses done the cycle after the last beat.
// Backpressure: one tbus op outstanding (ready only in IDLE); mem_req_* held until accepted.
// Ports: tbus_* request/completion from the LSU; mem_req_* / mem_rsp_* to the memory;
//        addresses in [MMIO_LO, MMIO_HI] go to memory as single uncached beats.
module tbus_dcache
    import tbus_dcache_pkg::*;
#(
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_BEATS = 4,
    parameter logic [63:0] MMIO_LO    = 64'h3000_0000,
    parameter logic [63:0] MMIO_HI    = 64'h4070_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tbus_index_valid,
    output logic        tbus_index_ready,
    input  logic [63:0] tbus_index,
    input  logic [63:0] tbus_write_data,
    input  logic [63:0] tbus_write_mask,
    input  logic [1:0]  tbus_operation_type,
    output logic [63:0] tbus_read_data,
    output logic        tbus_operation_done,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [63:0] mem_req_addr,
    output logic [7:0]  mem_req_len,
    output logic [63:0] mem_req_wdata,
    output logic [63:0] mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    input  logic        mem_rsp_last
);
    localparam int unsigned BEAT_W  = $clog2(LINE_BEATS);
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned OFF_W   = BEAT_W + 3;
    localparam int unsigned TAG_LSB = OFF_W + IDX_W;
    localparam int unsigned TAG_W   = 64 - TAG_LSB;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL_DATA,
        S_WR_REQ, S_WR_WAIT, S_UC_REQ, S_UC_WAIT
    } state_t;

    state_t              r_state, w_next;
    req_t                r_req;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_done, r_ready;
    logic [63:0]         r_rdata;

    logic [IDX_W-1:0]    w_idx;
    logic [BEAT_W-1:0]   w_req_beat, w_arr_beat;
    logic [TAG_W-1:0]    w_tag, w_line_tag;
    logic                w_line_vld, w_hit, w_mmio, w_accept, w_is_wr;
    logic [63:0]         w_rd_word, w_merged, w_arr_wdata, w_rdata_nxt;
    logic                w_arr_we, w_tag_we, w_done_set, w_rdata_ld;

    assign w_idx      = r_req.addr[OFF_W +: IDX_W];
    assign w_req_beat = r_req.addr[3 +: BEAT_W];
    assign w_tag      = r_req.addr[63:TAG_LSB];
    assign w_hit      = w_line_vld && (w_line_tag == w_tag);
    assign w_mmio     = (r_req.addr >= MMIO_LO) && (r_req.addr <= MMIO_HI);
    assign w_is_wr    = (r_req.op == TBUS_WRITE);
    assign w_merged   = (r_req.wdata & r_req.wmask) | (w_rd_word & ~r_req.wmask);
    // r_ready is only ever set while in IDLE, and is held low during reset.
    assign w_accept   = tbus_index_valid && r_ready;

    assign tbus_index_ready    = r_ready;
    assign tbus_operation_done = r_done;
    assign tbus_read_data      = r_rdata;

    dcache_array #(.SETS(SETS), .LINE_BEATS(LINE_BEATS), .TAG_W(TAG_W)) u_array (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_idx     (w_idx),
        .i_rd_beat (w_req_beat),
        .o_rd_data (w_rd_word),
        .o_valid   (w_line_vld),
        .o_tag     (w_line_tag),
        .i_we      (w_arr_we),
        .i_wr_beat (w_arr_beat),
        .i_wr_data (w_arr_wdata),
        .i_tag_we  (w_tag_we),
        .i_tag     (w_tag)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_done_set    = 1'b0;
        w_rdata_ld    = 1'b0;
        w_rdata_nxt   = mem_rsp_data;
        w_arr_we      = 1'b0;
        w_arr_beat    = w_req_beat;
        w_arr_wdata   = w_merged;
        w_tag_we      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_len   = '0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (w_mmio) begin
                    w_next = S_UC_REQ;
                end else if (!w_is_wr) begin
                    if (w_hit) begin
                        w_done_set  = 1'b1;
                        w_rdata_ld  = 1'b1;
                        w_rdata_nxt = w_rd_word;
                        w_next      = S_IDLE;
                    end else begin
                        w_next = S_REFILL_REQ;
                    end
                end else if (r_req.wmask == '0) begin
                    w_done_set = 1'b1;
                    w_next     = S_IDLE;
                end else begin
                    // Write-through: update the line only if resident, always go to memory.
                    w_arr_we = w_hit;
                    w_next   = S_WR_REQ;
                end
            end
            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {r_req.addr[63:OFF_W], {OFF_W{1'b0}}};
                mem_req_len   = 8'(LINE_BEATS - 1);
                if (mem_req_ready) w_next = S_REFILL_DATA;
            end
            S_REFILL_DATA: begin
                if (mem_rsp_valid) begin
                    w_arr_we    = 1'b1;
                    w_arr_beat  = r_beat;
                    w_arr_wdata = mem_rsp_data;
                    // Capture the requested word straight off the bus as it streams by.
                    w_rdata_ld  = (r_beat == w_req_beat);
                    if (mem_rsp_last) begin
                        w_tag_we   = 1'b1;
                        w_done_set = 1'b1;
                        w_next     = S_IDLE;
                    end
                end
            end
            S_WR_REQ, S_UC_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = w_is_wr;
                mem_req_addr  = word_addr(r_req.addr);
                mem_req_wdata = r_req.wdata;
                mem_req_wmask = r_req.wmask;
                if (mem_req_ready) w_next = (r_state == S_WR_REQ) ? S_WR_WAIT : S_UC_WAIT;
            end
            S_WR_WAIT, S_UC_WAIT: begin
                if (mem_rsp_valid && mem_rsp_last) begin
                    w_done_set = 1'b1;
                    w_rdata_ld = (r_state == S_UC_WAIT) && !w_is_wr;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req   <= '0;
            r_beat  <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= (w_next == S_IDLE);
            r_done  <= w_done_set;
            if (w_rdata_ld) r_rdata <= w_rdata_nxt;
            if (w_accept) begin
                r_req <= '{addr: tbus_index, wdata: tbus_write_data,
                           wmask: tbus_write_mask, op: tbus_operation_type};
            end
            if (r_state == S_LOOKUP)                           r_beat <= '0;
            else if (r_state == S_REFILL_DATA && mem_rsp_valid) r_beat <= r_beat + 1'b1;
        end
    end

endmodule

// File: tb/tb_tbus_dcache.sv
// Directed bench for tbus_dcache with a behavioural burst-memory responder.
// Memory returns an address-derived pattern (A5A5_0000 in the top half, word address below);
// stores are acknowledged but not retained.
module tb_tbus_dcache;
    import tbus_dcache_pkg::*;

    logic        clock, reset_n;
    logic        tbus_index_valid, tbus_index_ready;
    logic [63:0] tbus_index, tbus_write_data, tbus_write_mask, tbus_read_data;
    logic [1:0]  tbus_operation_type;
    logic        tbus_operation_done;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_req_wmask;
    logic [7:0]  mem_req_len;
    logic        mem_rsp_valid, mem_rsp_last;
    logic [63:0] mem_rsp_data;

    int          checks = 0;
    int          errors = 0;

    int          req_cnt = 0;
    int          rsp_beat = 0;
    logic        cap_write;
    logic [63:0] cap_addr, cap_wdata, cap_wmask;
    logic [7:0]  cap_len;

    tbus_dcache dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .tbus_index_valid    (tbus_index_valid),
        .tbus_index_ready    (tbus_index_ready),
        .tbus_index          (tbus_index),
        .tbus_write_data     (tbus_write_data),
        .tbus_write_mask     (tbus_write_mask),
        .tbus_operation_type (tbus_operation_type),
        .tbus_read_data      (tbus_read_data),
        .tbus_operation_done (tbus_operation_done),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_write       (mem_req_write),
        .mem_req_addr        (mem_req_addr),
        .mem_req_len         (mem_req_len),
        .mem_req_wdata       (mem_req_wdata),
        .mem_req_wmask       (mem_req_wmask),
        .mem_rsp_valid       (mem_rsp_valid),
        .mem_rsp_data        (mem_rsp_data),
        .mem_rsp_last        (mem_rsp_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: accepts a request on the negedge it is seen, then streams
    // len+1 beats on consecutive cycles; abandons the burst if reset is asserted.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clock);
            if (reset_n && mem_req_valid) begin
                mem_req_ready = 1'b1;
                cap_write = mem_req_write;
                cap_addr  = mem_req_addr;
                cap_len   = mem_req_len;
                cap_wdata = mem_req_wdata;
                cap_wmask = mem_req_wmask;
                req_cnt++;
                @(negedge clock);
                mem_req_ready = 1'b0;
                for (int i = 0; i <= int'(cap_len) && reset_n; i++) begin
                    rsp_beat      = i;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_last  = (i == int'(cap_len));
                    mem_rsp_data  = cap_write ? 64'd0
                                              : (64'hA5A5_0000_0000_0000 | (cap_addr + 64'(i * 8)));
                    @(negedge clock);
                end
                mem_rsp_valid = 1'b0;
                mem_rsp_last  = 1'b0;
                mem_rsp_data  = '0;
            end
        end
    end

    // Issues one tbus op; lat counts cycles from the accept cycle (0) to the done cycle.
    task automatic do_op(input logic [1:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] wmask,
                         output logic [63:0] rdata, output int lat);
        int n;
        @(negedge clock);
        tbus_index_valid    = 1'b1;
        tbus_index          = addr;
        tbus_write_data     = wdata;
        tbus_write_mask     = wmask;
        tbus_operation_type = op;
        n = 0;
        while (!tbus_index_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        tbus_index_valid = 1'b0;
        lat = 1;
        while (!tbus_operation_done && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        chk("op_completed", 64'(tbus_operation_done), 64'd1);
        rdata = tbus_read_data;
    endtask

    initial begin
        logic [63:0] rd;
        int          lat;
        int          req0;
        bit          saw_done;
        bit          hit2;

        reset_n             = 1'b0;
        tbus_index_valid    = 1'b0;
        tbus_index          = '0;
        tbus_write_data     = '0;
        tbus_write_mask     = '0;
        tbus_operation_type = TBUS_READ;
        repeat (3) @(negedge clock);
        chk("rst_ready",     64'(tbus_index_ready),    64'd0);
        chk("rst_done",      64'(tbus_operation_done), 64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid),       64'd0);
        chk("rst_rdata",     tbus_read_data,           64'd0);
        chk("rst_mem_addr",  mem_req_addr,             64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_ready", 64'(tbus_index_ready), 64'd1);

        // 1: cold read miss, full refill, requested word is beat 2
        req0 = req_cnt;
        do_op(TBUS_READ, 64'h8000_0010, '0, '0, rd, lat);
        chk("t1_data",  rd, 64'hA5A5_0000_8000_0010);
        chk("t1_nreq",  64'(req_cnt - req0), 64'd1);
        chk("t1_addr",  cap_addr, 64'h8000_0000);
        chk("t1_len",   64'(cap_len), 64'd3);
        chk("t1_write", 64'(cap_write), 64'd0);
        chk("t1_idle",  64'(tbus_index_ready), 64'd1);

        // 2: hit on the same line, last beat
        req0 = req_cnt;
        do_op(TBUS_READ, 64'h8000_0018, '0, '0, rd, lat);
        chk("t2_data", rd, 64'hA5A5_0000_8000_0018);
        chk("t2_lat",  64'(lat), 64'd2);
        chk("t2_nreq", 64'(req_cnt - req0), 64'd0);
        @(negedge clock);
        chk("t2_done_pulse", 64'(tbus_operation_done), 64'd0);

        // 3: write hit merges low byte and writes through
        req0 = req_cnt;
        do_op(TBUS_WRITE, 64'h8000_0010, 64'hFF, 64'hFF, rd, lat);
        chk("t3_nreq",  64'(req_cnt - req0), 64'd1);
        chk("t3_write", 64'(cap_write), 64'd1);
        chk("t3_addr",  cap_addr, 64'h8000_0010);
        chk("t3_len",   64'(cap_len), 64'd0);
        chk("t3_wdata", cap_wdata, 64'hFF);
        chk("t3_wmask", cap_wmask, 64'hFF);
        req0 = req_cnt;
        do_op(TBUS_READ, 64'h8000_0010, '0, '0, rd, lat);
        chk("t3_merged", rd, 64'hA5A5_0000_8000_00FF);
        chk("t3_rd_nreq", 64'(req_cnt - req0), 64'd0);

        // Empty mask: completes locally
        req0 = req_cnt;
        do_op(TBUS_WRITE, 64'h8000_0000, 64'h1234, 64'd0, rd, lat);
        chk("m0_nreq", 64'(req_cnt - req0), 64'd0);
        chk("m0_lat",  64'(lat), 64'd2);

        // 4: write miss (same set, different tag) must not allocate or disturb the set
        req0 = req_cnt;
        do_op(TBUS_WRITE, 64'h9000_0000, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, rd, lat);
        chk("t4_nreq",  64'(req_cnt - req0), 64'd1);
        chk("t4_write", 64'(cap_write), 64'd1);
        chk("t4_addr",  cap_addr, 64'h9000_0000);
        req0 = req_cnt;
        do_op(TBUS_READ, 64'h8000_0010, '0, '0, rd, lat);
        chk("t4_old_line", rd, 64'hA5A5_0000_8000_00FF);
        chk("t4_old_nreq", 64'(req_cnt - req0), 64'd0);
        req0 = req_cnt;
        do_op(TBUS_READ, 64'h9000_0000, '0, '0, rd, lat);
        chk("t4_rd_data", rd, 64'hA5A5_0000_9000_0000);
        chk("t4_rd_nreq", 64'(req_cnt - req0), 64'd1);
        chk("t4_rd_len",  64'(cap_len), 64'd3);
        chk("t4_rd_addr", cap_addr, 64'h9000_0000);

        // 5: uncached reads, including the top of the window
        for (int k = 0; k < 2; k++) begin
            req0 = req_cnt;
            do_op(TBUS_READ, 64'h3000_0000, '0, '0, rd, lat);
            chk("t5_uc_data", rd, 64'hA5A5_0000_3000_0000);
            chk("t5_uc_nreq", 64'(req_cnt - req0), 64'd1);
            chk("t5_uc_len",  64'(cap_len), 64'd0);
        end
        do_op(TBUS_READ, 64'h4070_0000, '0, '0, rd, lat);
        chk("t5_hi_len",  64'(cap_len), 64'd0);
        chk("t5_hi_data", rd, 64'hA5A5_0000_4070_0000);
        req0 = req_cnt;
        do_op(TBUS_READ, 64'h9000_0000, '0, '0, rd, lat);
        chk("t5_still_hit", 64'(req_cnt - req0), 64'd0);
        chk("t5_hit_lat",   64'(lat), 64'd2);

        // 6: reset during refill beat 2
        req0 = req_cnt;
        @(negedge clock);
        chk("t6_ready", 64'(tbus_index_ready), 64'd1);
        tbus_index_valid    = 1'b1;
        tbus_index          = 64'hA000_0000;
        tbus_operation_type = TBUS_READ;
        @(negedge clock);
        tbus_index_valid = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < 20 && !hit2; k++) begin
            @(negedge clock);
            #1;
            if (mem_rsp_valid && rsp_beat == 2) hit2 = 1'b1;
        end
        chk("t6_reached_beat2", 64'(hit2), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(tbus_index_ready), 64'd0);
        chk("t6_rst_done",  64'(tbus_operation_done), 64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (tbus_operation_done) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (tbus_operation_done) saw_done = 1'b1;
        end
        chk("t6_no_done", 64'(saw_done), 64'd0);
        chk("t6_nreq",    64'(req_cnt - req0), 64'd1);
        req0 = req_cnt;
        do_op(TBUS_READ, 64'h9000_0000, '0, '0, rd, lat);
        chk("t6_reread_nreq", 64'(req_cnt - req0), 64'd1);
        chk("t6_reread_len",  64'(cap_len), 64'd3);
        chk("t6_reread_data", rd, 64'hA5A5_0000_9000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
